// File: rtl/instr_encoder.sv
// Packs decoded RV32I+F fields into instruction words behind a small FIFO.
// Optional ENC_STATS_EN adds saturating push / reject counters.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [5:0]  rs1_addr,
  input  logic [5:0]  rs2_addr,
  input  logic [5:0]  rd_addr,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
`ifdef ENC_STATS_EN
  output logic [31:0] enc_count,
  output logic [15:0] err_count,
`endif
  output logic        err_valid,
  output logic [1:0]  err_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_FALU  = 7'b1010011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_FLW   = 7'b0000111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_FSW   = 7'b0100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;

  logic [31:0] enc;
  logic [1:0]  err;
  logic        bad_op, bad_reg, bad_imm;
  logic        f1, f2, fd, shift;
  logic        sext12, sext13, sext21;
  logic        accept, push, pop;

  assign f1     = rs1_addr[5];
  assign f2     = rs2_addr[5];
  assign fd     = rd_addr[5];
  assign shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign sext12 = (&imm[31:11]) || ~(|imm[31:11]);
  assign sext13 = (&imm[31:12]) || ~(|imm[31:12]);
  assign sext21 = (&imm[31:20]) || ~(|imm[31:20]);

  always_comb begin
    enc     = '0;
    bad_op  = 1'b0;
    bad_reg = 1'b0;
    bad_imm = 1'b0;
    case (opcode)
      OP_R, OP_FALU: begin
        enc = {funct7, rs2_addr[4:0], rs1_addr[4:0],
               funct3, rd_addr[4:0], opcode};
        if (opcode == OP_FALU) bad_reg = !(f1 && f2 && fd);
        else                   bad_reg = f1 || f2 || fd;
      end
      OP_I, OP_LOAD, OP_FLW, OP_JALR, OP_CSR: begin
        enc = {imm[11:0], rs1_addr[4:0], funct3,
               rd_addr[4:0], opcode};
        if (opcode == OP_FLW) bad_reg = !fd || f1;
        else                  bad_reg = fd || f1;
        if (opcode == OP_CSR) bad_imm = |imm[31:12];
        else                  bad_imm = !sext12;
        // Shift amount lives in imm[4:0]; the top bits come from funct7
        if (opcode == OP_I && shift) begin
          enc[31:20] = {funct7, imm[4:0]};
          bad_imm    = |imm[31:5];
        end
      end
      OP_STORE, OP_FSW: begin
        enc = {imm[11:5], rs2_addr[4:0], rs1_addr[4:0],
               funct3, imm[4:0], opcode};
        if (opcode == OP_FSW) bad_reg = !f2 || f1;
        else                  bad_reg = f2 || f1;
        bad_imm = !sext12;
      end
      OP_BR: begin
        enc = {imm[12], imm[10:5], rs2_addr[4:0], rs1_addr[4:0],
               funct3, imm[4:1], imm[11], opcode};
        bad_reg = f1 || f2;
        bad_imm = imm[0] || !sext13;
      end
      OP_LUI, OP_AUIPC: begin
        enc     = {imm[31:12], rd_addr[4:0], opcode};
        bad_reg = fd;
        bad_imm = |imm[11:0];
      end
      OP_JAL: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12],
               rd_addr[4:0], opcode};
        bad_reg = fd;
        bad_imm = imm[0] || !sext21;
      end
      default: bad_op = 1'b1;
    endcase
  end

  always_comb begin
    err = 2'd0;
    if (bad_op)       err = 2'd3;
    else if (bad_reg) err = 2'd1;
    else if (bad_imm) err = 2'd2;
  end

  assign in_ready  = (count_q != CW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && (err == 2'd0);
  assign pop    = out_valid && out_ready;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CW'(push) - CW'(pop);
    err_valid_d = accept && (err != 2'd0);
    err_code_d  = accept ? err : 2'd0;
    if (push) begin
      mem_d[wr_ptr_q] = enc;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
    mem_q <= mem_d;
  end

`ifdef ENC_STATS_EN
  logic [31:0] enc_count_q, enc_count_d;
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (push && !(&enc_count_q)) enc_count_d = enc_count_q + 1'b1;
    if (err_valid_d && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign enc_count = enc_count_q;
  assign err_count = err_count_q;
`endif

endmodule
